// File: rtl/t01_keypad_scan_if.sv
// Key matrix scanner bus: scan control and row sense in, column drive,
// debounced key vector and frame pulse out.
interface t01_keypad_scan_if;
    logic        scan_en;
    logic [3:0]  row_in;
    logic [4:0]  col_drive;
    logic [19:0] keys;
    logic        frame_done;

    // Side that controls scanning and owns the key matrix
    modport master (
        output scan_en,
        output row_in,
        input  col_drive,
        input  keys,
        input  frame_done
    );

    // The scanner itself
    modport slave (
        input  scan_en,
        input  row_in,
        output col_drive,
        output keys,
        output frame_done
    );
endinterface

// File: rtl/t01_keypad_scan.sv
// 4-row x 5-column key matrix scanner with row synchronizer and
// whole-frame debounce. Drives one column at a time, assembles a 20-bit
// frame and reports it on keys once it has repeated enough scans.
module t01_keypad_scan #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              rst,
    t01_keypad_scan_if.slave  bus
);

    localparam logic [7:0] CNT_LAST    = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] STABLE_LAST = 4'(DEBOUNCE_SCANS - 1);

    typedef enum logic {
        ST_SCAN,
        ST_PAUSE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        restart;

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;

    logic [2:0]  col;
    logic [7:0]  cnt;
    logic [3:0]  stable;
    logic [3:0]  stable_next;
    logic [19:0] prev_frame;
    logic [19:0] new_frame;
    logic [15:0] partial;
    logic [4:0]  col_drive_q;
    logic [19:0] keys_q;
    logic        frame_done_q;

    assign bus.col_drive  = col_drive_q;
    assign bus.keys       = keys_q;
    assign bus.frame_done = frame_done_q;

    // Two-flop synchronizer: row_in is asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'd0;
            row_sync <= 4'd0;
        end else begin
            row_meta <= bus.row_in;
            row_sync <= row_meta;
        end
    end

    // Scan/pause state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pause whenever scan_en drops; the first enabled edge out of pause restarts at column 0
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (!bus.scan_en) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.scan_en) begin
                    state_d = ST_SCAN;
                    restart = 1'b1;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Completed frame and its updated stable count (valid on the column 4 capture edge)
    always_comb begin
        new_frame   = {row_sync, partial};
        stable_next = 4'd0;
        if (new_frame == prev_frame) begin
            stable_next = (stable == STABLE_LAST) ? stable : stable + 4'd1;
        end
    end

    // Column sequencing, frame assembly and debounce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= 3'd0;
            cnt          <= 8'd0;
            stable       <= 4'd0;
            prev_frame   <= 20'd0;
            partial      <= 16'd0;
            col_drive_q  <= 5'b00001;
            keys_q       <= 20'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!bus.scan_en) begin
                col_drive_q <= 5'b00000;
                partial     <= 16'd0;
            end else if (restart) begin
                col         <= 3'd0;
                cnt         <= 8'd0;
                col_drive_q <= 5'b00001;
            end else if (cnt == CNT_LAST) begin
                cnt <= 8'd0;
                if (col == 3'd4) begin
                    col          <= 3'd0;
                    col_drive_q  <= 5'b00001;
                    prev_frame   <= new_frame;
                    stable       <= stable_next;
                    frame_done_q <= 1'b1;
                    if (stable_next == STABLE_LAST) begin
                        keys_q <= new_frame;
                    end
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (col == 3'(i)) begin
                            partial[i*4 +: 4] <= row_sync;
                        end
                    end
                    col         <= col + 3'd1;
                    col_drive_q <= col_drive_q << 1;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule
